// File: rtl/mux_bus_arbiter.sv
// Two-requester round-robin arbiter driving a 2:1 bus mux, with bounded bursts
// and a one-entry registered output stage (valid/ready on every side).
module mux_bus_arbiter #(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             sel_mux
);

  localparam int            CW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t        state, state_nxt;
  logic          last_grant, last_grant_nxt;   // 0=A, 1=B
  logic [CW-1:0] burst_cnt, burst_cnt_nxt;
  logic          can_load, a_xfer, b_xfer, xfer;

  assign can_load = ~out_valid | out_ready;
  assign a_xfer   = a_valid & a_ready;
  assign b_xfer   = b_valid & b_ready;
  assign xfer     = a_xfer | b_xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    case (state)
      IDLE: begin
        // Tie goes to whoever was not granted last.
        if (a_valid && (!b_valid || last_grant)) begin
          state_nxt      = GRANT_A;
          last_grant_nxt = 1'b0;
          burst_cnt_nxt  = '0;
        end else if (b_valid) begin
          state_nxt      = GRANT_B;
          last_grant_nxt = 1'b1;
          burst_cnt_nxt  = '0;
        end
      end
      GRANT_A: begin
        if (a_valid) begin
          if (a_xfer) begin
            if (burst_cnt == LAST) begin
              burst_cnt_nxt = '0;
              if (b_valid) begin
                state_nxt      = GRANT_B;
                last_grant_nxt = 1'b1;
              end
            end else begin
              burst_cnt_nxt = burst_cnt + 1'b1;
            end
          end
        end else if (b_valid) begin
          state_nxt      = GRANT_B;
          last_grant_nxt = 1'b1;
          burst_cnt_nxt  = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT_B: begin
        if (b_valid) begin
          if (b_xfer) begin
            if (burst_cnt == LAST) begin
              burst_cnt_nxt = '0;
              if (a_valid) begin
                state_nxt      = GRANT_A;
                last_grant_nxt = 1'b0;
              end
            end else begin
              burst_cnt_nxt = burst_cnt + 1'b1;
            end
          end
        end else if (a_valid) begin
          state_nxt      = GRANT_A;
          last_grant_nxt = 1'b0;
          burst_cnt_nxt  = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Readies depend only on grant state and output-stage space.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    sel_mux = 1'b0;
    case (state)
      GRANT_A: a_ready = can_load;
      GRANT_B: begin
        b_ready = can_load;
        sel_mux = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_mux ? b_data : a_data;
      out_src   <= sel_mux;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Scoreboard bench for mux_bus_arbiter: expected beats are queued per scenario
// and popped as the output stage hands them over.
module tb_mux_bus_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, b_valid, out_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, out_valid, out_src, sel_mux;
  logic [W-1:0] out_data;

  mux_bus_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .sel_mux(sel_mux)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] a_q[$], b_q[$];
  logic [W:0]   exp_q[$];           // {src, data}
  int           ai, bi;
  int           stall_from, stall_len;
  logic         log_ar[64], log_br[64], log_sel[64];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b1;
    a_q.delete(); b_q.delete(); exp_q.delete();
    ai = 0; bi = 0; stall_from = 1000; stall_len = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive queued beats, consume output, check every cycle.
  task automatic run(input int max_cyc, input bit need_done);
    logic         held_v = 1'b0;
    logic [W:0]   held = '0;
    logic [W:0]   e;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (need_done && exp_q.size() == 0 && ai == a_q.size() && bi == b_q.size()) break;
      @(negedge clk);
      a_valid   = (ai < a_q.size());
      a_data    = a_valid ? a_q[ai] : '0;
      b_valid   = (bi < b_q.size());
      b_data    = b_valid ? b_q[bi] : '0;
      out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      #1;
      if (cyc < 64) begin
        log_ar[cyc] = a_ready; log_br[cyc] = b_ready; log_sel[cyc] = sel_mux;
      end
      checks++;
      if ((a_ready && b_ready) || (a_ready && sel_mux !== 1'b0) || (b_ready && sel_mux !== 1'b1)) begin
        errors++;
        $display("FAIL ready_sel cyc=%0d: a_ready=%b b_ready=%b sel_mux=%b", cyc, a_ready, b_ready, sel_mux);
      end
      if (held_v) begin
        checks++;
        if ({out_src, out_data} !== held || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL hold cyc=%0d: got v=%b %h, required v=1 %h", cyc, out_valid, {out_src, out_data}, held);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready cyc=%0d: a_ready=%b b_ready=%b, required 0", cyc, a_ready, b_ready);
        end
        held_v = 1'b1; held = {out_src, out_data};
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat cyc=%0d: got %h, required none", cyc, {out_src, out_data});
        end else begin
          e = exp_q.pop_front();
          if ({out_src, out_data} !== e) begin
            errors++;
            $display("FAIL beat cyc=%0d: got src/data %h, required %h", cyc, {out_src, out_data}, e);
          end
        end
      end
      if (a_valid && a_ready) ai++;
      if (b_valid && b_ready) bi++;
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1; stall_from = 1000;
    if (need_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d beats missing, required 0", exp_q.size());
      end
    end
  endtask

  task automatic push_a(input logic [W-1:0] d);
    a_q.push_back(d); exp_q.push_back({1'b0, d});
  endtask

  task automatic push_b(input logic [W-1:0] d);
    b_q.push_back(d); exp_q.push_back({1'b1, d});
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b1;
    #12;
    checks++;
    if ({out_valid, out_data, out_src, sel_mux, a_ready, b_ready} !== '0) begin
      errors++;
      $display("FAIL reset: v=%b d=%h src=%b sel=%b ar=%b br=%b, required all 0",
               out_valid, out_data, out_src, sel_mux, a_ready, b_ready);
    end
    do_reset();
  endtask

  task automatic test_single_a();
    do_reset();
    for (int i = 0; i < 4; i++) push_a(16'h1111 + W'(i));
    run(30, 1'b1);
    checks++;
    if (log_ar[0] !== 1'b0 || log_ar[1] !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: a_ready c0=%b c1=%b, required 0 1", log_ar[0], log_ar[1]);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 4; i++) push_a(16'hA000 + W'(g * 4 + i));
      for (int i = 0; i < 4; i++) push_b(16'hB000 + W'(g * 4 + i));
    end
    run(60, 1'b1);
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) push_a(16'h5A00 + W'(i));
    for (int i = 0; i < 4; i++) push_b(16'h5B00 + W'(i));
    push_a(16'h5A04); push_a(16'h5A05);
    stall_from = 3; stall_len = 3;
    run(40, 1'b1);
  endtask

  task automatic test_early_release();
    do_reset();
    push_a(16'h0A01); push_a(16'h0A02); push_b(16'hBEEF);
    run(20, 1'b1);
    checks++;
    if (log_br[3] !== 1'b0 || log_br[4] !== 1'b1 || log_sel[4] !== 1'b1) begin
      errors++;
      $display("FAIL early_release: b_ready c3=%b c4=%b sel c4=%b, required 0 1 1",
               log_br[3], log_br[4], log_sel[4]);
    end
  endtask

  task automatic test_only_b();
    logic ok = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) push_b(16'hB100 + W'(i));
    run(20, 1'b1);
    for (int i = 1; i <= 6; i++) if (log_br[i] !== 1'b1) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL only_b_contig: b_ready c1..6 = %b%b%b%b%b%b, required 111111",
               log_br[1], log_br[2], log_br[3], log_br[4], log_br[5], log_br[6]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) push_a(16'hC000 + W'(i));
    run(4, 1'b0);
    #2;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: out_valid=%b, required 1", out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0 || sel_mux !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: v=%b ar=%b br=%b sel=%b, required 0 0 0 0",
               out_valid, a_ready, b_ready, sel_mux);
    end
    a_q.delete(); b_q.delete(); exp_q.delete(); ai = 0; bi = 0;
    @(negedge clk);
    rst = 1'b0;
    push_a(16'hD00A); push_b(16'hD00B);
    run(20, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_only_b();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
